// File: rtl/seq_compare_ctrl_pkg.sv
// rtl/seq_compare_ctrl_pkg.sv - shared FSM encoding and index-width helper for seq_compare_ctrl
package seq_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for n steps; never narrower than one bit so N=1 still has an idx register.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_compare_ctrl_cmp2_slice.sv
// rtl/seq_compare_ctrl_cmp2_slice.sv - combinational 2-bit unsigned magnitude compare slice
module cmp2_slice (
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  output logic lt,
  output logic gt,
  output logic eq
);

  logic [1:0] va;
  logic [1:0] vb;

  assign va = {a1, a0};
  assign vb = {b1, b0};
  assign lt = (va < vb);
  assign gt = (va > vb);
  assign eq = (va == vb);

endmodule

// File: rtl/seq_compare_ctrl.sv
// rtl/seq_compare_ctrl.sv - multi-cycle WIDTH-bit comparator walking 2-bit pairs MSB first
// Optional macro CMP_EARLY_EXIT_EN: finish as soon as the first differing pair is found.
module seq_compare_ctrl
  import seq_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int N  = WIDTH / 2;
  localparam int IW = idx_width(N);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             decided_q, decided_d;
  logic             dlt_q, dlt_d;
  logic             dgt_q, dgt_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;

  logic [1:0] pa, pb;
  logic       s_lt, s_gt, s_eq;
  logic       accept;
  logic       last_step;

  always_comb begin
    pa = '0;
    pb = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) begin
        pa = a_q[2*i +: 2];
        pb = b_q[2*i +: 2];
      end
    end
  end

  cmp2_slice u_slice (
    .a1 (pa[1]),
    .a0 (pa[0]),
    .b1 (pb[1]),
    .b0 (pb[0]),
    .lt (s_lt),
    .gt (s_gt),
    .eq (s_eq)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    dlt_d     = dlt_q;
    dgt_d     = dgt_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    eq_d      = eq_q;
    accept    = 1'b0;
    last_step = 1'b0;

    case (state_q)
      ST_IDLE: accept = start;
      ST_RUN: begin
        // Only the first differing pair counts; lower pairs cannot change the verdict.
        if (!decided_q && !s_eq) begin
          decided_d = 1'b1;
          dlt_d     = s_lt;
          dgt_d     = s_gt;
        end
        last_step = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
        if (!decided_q && !s_eq) last_step = 1'b1;
`endif
        if (last_step) begin
          state_d = ST_DONE;
          lt_d    = dlt_d;
          gt_d    = dgt_d;
          eq_d    = !decided_d;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_DONE: begin
        accept = start;
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d   = ST_RUN;
      a_d       = a;
      b_d       = b;
      idx_d     = IW'(N - 1);
      decided_d = 1'b0;
      dlt_d     = 1'b0;
      dgt_d     = 1'b0;
      lt_d      = 1'b0;
      gt_d      = 1'b0;
      eq_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      dlt_q     <= 1'b0;
      dgt_q     <= 1'b0;
      lt_q      <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      dlt_q     <= dlt_d;
      dgt_q     <= dgt_d;
      lt_q      <= lt_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_seq_compare_ctrl.sv
// tb/tb_seq_compare_ctrl.sv - randomized scoreboard bench for seq_compare_ctrl (WIDTH=8)
module tb_seq_compare_ctrl;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, lt, gt, eq;

  typedef struct {
    logic lt;
    logic gt;
    logic eq;
    int   lat;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  seq_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .gt    (gt),
    .eq    (eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain arithmetic verdict; latency from the MSB-first position of the first differing pair.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t r;
    int   p;
    int   xv, yv;
    xv   = int'(x);
    yv   = int'(y);
    r.lt = (xv < yv);
    r.gt = (xv > yv);
    r.eq = (xv == yv);
    p = 0;
    for (int k = 1; k <= N; k++) begin
      if (p == 0 && (((xv >> (2 * (N - k))) & 3) != ((yv >> (2 * (N - k))) & 3))) p = k;
    end
`ifdef CMP_EARLY_EXIT_EN
    r.lat = (p == 0) ? N + 1 : p + 1;
`else
    r.lat = N + 1;
`endif
    r.cyc = 0;
    return r;
  endfunction

  task automatic mon_step();
    exp_t e;
    if (!rst_n) return;
    if (busy) chk("cleared_in_run", int'({lt, gt, eq}), 0);
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result_ltgteq", int'({lt, gt, eq}), int'({e.lt, e.gt, e.eq}));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  endtask

  // Entered and left at posedge+1; leaves in the DONE cycle of its own transaction.
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input int gap);
    exp_t e;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = model(ta, tb_v);
    e.cyc = cyc + e.lat - 1;
    exp_q.push_back(e);
    for (int i = 0; i < e.lat - 1; i++) begin
      start = 1'($urandom);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    @(negedge clk);
    chk("reset_outputs", int'({busy, done, lt, gt, eq}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_txn(8'hA5, 8'hA5, 1);
    run_txn(8'h80, 8'h7F, 1);
    run_txn(8'h12, 8'h13, 1);
    run_txn(8'h01, 8'h02, 1);

    // Reset in the middle of RUN: outputs drop at once and the aborted compare never reports.
    a     = 8'h01;
    b     = 8'h02;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", int'({busy, done, lt, gt, eq}), 0);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (N + 3) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, d0);

    run_txn(8'h12, 8'h13, 0);
    run_txn(8'h40, 8'h40, 0);

    for (int t = 0; t < 40; t++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      run_txn(ra, rb, $urandom_range(0, 2));
    end

    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
